lsu_align_unit: RTL and testbench
=================================

Name: lsu_align_unit

Overview:
- Parametrised load/store alignment unit between the MEM-stage request and the data-memory bus.
- Generalises the combinational load extender:
  - configurable data width: 32 or 64
  - byte, half, word and dword sizes with sign or zero extension
  - byte enables generated for stores
  - misaligned accesses split into two aligned bus beats, driven by a multi-cycle FSM with valid/ready handshakes
- Holds at most one request at a time.

Parameters:
DW, 32, data width in bits; legal values are 32 and 64.
AW, 32, address width in bits.
ALLOW_MISALIGN, 1, 1 splits boundary-crossing accesses into two beats; 0 reports them as errors.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  unit can accept a request.
req_we  input  1  1 = store, 0 = load.
req_op  input  3  [1:0] size (0 byte, 1 half, 2 word, 3 dword); [2] zero-extend.
req_addr  input  AW  byte address.
req_wdata  input  DW  store data, LSB-justified.
resp_valid  output  1  one-cycle completion pulse.
resp_rdata  output  DW  extended load data; 0 for stores.
resp_err  output  1  illegal size or disallowed misalignment.
mem_valid  output  1  bus command valid.
mem_ready  input  1  bus accepts command.
mem_we  output  1  bus write.
mem_addr  output  AW  bus address, aligned to DW/8.
mem_be  output  DW/8  byte enables.
mem_wdata  output  DW  lane-shifted store data.
mem_rvalid  input  1  read data valid.
mem_rdata  input  DW  read data.

Behaviour:
- Reset (reset low, asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0, except req_ready, which is 1.
  - Internal registers are cleared.
  - An in-flight mem_valid is dropped immediately.
- States: IDLE, CMD0, RD0, CMD1, RD1, RESP.
- IDLE:
  - req_ready=1.
  - Request accepted on req_valid & req_ready; addr, op, we and wdata are latched.
- Byte count and offset:
  - N = 1<<size.
  - off = addr mod (DW/8).
  - Request is misaligned when off+N > DW/8 (crosses the bus word boundary).
- Error: size==3 with DW==32, or misaligned with ALLOW_MISALIGN=0.
  - Next state RESP with resp_err=1 and resp_rdata=0.
  - No bus activity.
- CMD0:
  - Drives mem_valid=1, mem_addr = addr with the low bits cleared, and mem_we.
  - mem_be = ((1<<N)-1) << off, truncated to DW/8 bits.
  - mem_wdata = wdata << (8*off).
  - All command signals are held stable until mem_ready.
  - On handshake:
    - load → RD0
    - store, two beats → CMD1
    - store, single beat → RESP
- RD0:
  - Waits for mem_rvalid; captures mem_rdata into the low-beat buffer.
  - Then → CMD1 if two beats, else RESP.
- CMD1:
  - mem_addr = beat0 address + DW/8, wrapping modulo 2^AW.
  - mem_be = remaining low bytes: (1<<(off+N-DW/8))-1.
  - mem_wdata = wdata >> (8*(DW/8-off)).
  - On handshake: load → RD1, store → RESP.
- RD1: captures the high beat → RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, then → IDLE.
  - Responses cannot be back-pressured.
- Load assembly:
  - Concatenate {beat1, beat0} (beat1 = 0 when single beat), shift right by 8*off, keep N bytes.
  - Sign-extend from bit 8N-1 unless req_op[2] is set.
  - Dword, or word when DW=32, passes through unextended.
- Latency (zero bus wait states; mem_ready=1, mem_rvalid the cycle after the handshake):
  - aligned load: resp_valid 3 cycles after accept
  - misaligned load: 5 cycles after accept
  - aligned store: 2 cycles after accept
  - misaligned store: 3 cycles after accept
- mem_rvalid outside RD0/RD1 is ignored, including stale data arriving after a reset.
- Same-cycle req_valid during RESP is not accepted; req_ready=0.

Decomposition:
- Shared constants header: size codes (LSU_SZ_B/H/W/D), zero-extend bit position, FSM state encodings.
- One natural sub-module, lsu_load_extend: combinational shift/extract/extend of the two-beat concatenation, parametrised by DW.

Test Plan:
- DW=32, lb, addr 0x1003, mem word 0x80FF7F01 → resp_rdata 0xFFFFFF80; lbu same → 0x00000080; 3 cycles after accept, err 0.
- DW=32, sh, addr 0x2002, wdata 0x0000BEEF → mem_addr 0x2000, be 4'b1100, mem_wdata 0xBEEF0000; resp 2 cycles after accept.
- DW=32, misaligned lw, addr 0x3003, beats 0x44332211 then 0x88776655 → two reads at 0x3000 and 0x3004; resp_rdata 0x77665544; 5 cycles after accept.
- DW=32, misaligned sw, addr 0x3002, wdata 0xAABBCCDD → beat0 be 1100, wdata 0xCCDD0000; beat1 addr 0x3004, be 0011, wdata 0x0000AABB.
- ALLOW_MISALIGN=0, lh at 0x0003 → mem_valid never asserted; resp_err=1, rdata 0. DW=32, dword request → resp_err=1.
- mem_ready held 0 for 4 cycles in CMD0, then reset pulsed low → mem_valid drops asynchronously; req_ready=1 after release; a late mem_rvalid is ignored with no resp_valid.

Source files
------------

// File: rtl/lsu_align_unit_pkg.sv
// lsu_align_unit_pkg: shared size codes, extend-control bit and FSM states for the load/store alignment unit.
package lsu_align_unit_pkg;
    localparam logic [1:0] LSU_SZ_B = 2'd0;
    localparam logic [1:0] LSU_SZ_H = 2'd1;
    localparam logic [1:0] LSU_SZ_W = 2'd2;
    localparam logic [1:0] LSU_SZ_D = 2'd3;
    localparam int LSU_ZX_BIT = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD0,
        S_RD0,
        S_CMD1,
        S_RD1,
        S_RESP
    } state_t;
endpackage

// File: rtl/lsu_load_extend.sv
// lsu_load_extend: extracts the addressed bytes from a two-beat read and sign/zero extends them.
module lsu_load_extend
    import lsu_align_unit_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [2*DW-1:0]         beats,
    input  logic [$clog2(DW/8)-1:0] off,
    input  logic [2:0]              op,
    output logic [DW-1:0]           data
);
    localparam logic [DW-1:0] ONE = 1;
    logic [DW-1:0] s;
    logic [DW-1:0] mask;
    logic [6:0]    nbits;
    logic          sign;

    // a size as wide as the bus yields an all-ones mask, so nothing gets extended
    always_comb begin
        s     = DW'(beats >> {off, 3'b000});
        nbits = 7'd8 << op[1:0];
        mask  = (ONE << nbits) - ONE;
        sign  = |(s & (ONE << (nbits - 7'd1))) && !op[LSU_ZX_BIT];
        data  = (s & mask) | (sign ? ~mask : '0);
    end
endmodule

// File: rtl/lsu_align_unit.sv
// lsu_align_unit: aligns MEM-stage loads/stores onto the data bus, splitting
// boundary-crossing accesses into two aligned beats.
module lsu_align_unit
    import lsu_align_unit_pkg::*;
#(
    parameter int DW             = 32,
    parameter int AW             = 32,
    parameter int ALLOW_MISALIGN = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_we,
    input  logic [2:0]     req_op,
    input  logic [AW-1:0]  req_addr,
    input  logic [DW-1:0]  req_wdata,
    output logic           resp_valid,
    output logic [DW-1:0]  resp_rdata,
    output logic           resp_err,
    output logic           mem_valid,
    input  logic           mem_ready,
    output logic           mem_we,
    output logic [AW-1:0]  mem_addr,
    output logic [DW/8-1:0] mem_be,
    output logic [DW-1:0]  mem_wdata,
    input  logic           mem_rvalid,
    input  logic [DW-1:0]  mem_rdata
);
    localparam int BW = DW / 8;
    localparam int OW = $clog2(BW);
    localparam logic [2*BW-1:0] BE_ONE = 1;

    state_t          state, state_nx;
    logic [AW-1:0]   addr_q, base;
    logic [2:0]      op_q;
    logic            we_q, err_q;
    logic [DW-1:0]   wdata_q, beat0, beat1, load_data;
    logic [OW-1:0]   off, in_off;
    logic            two, in_mis, in_err;
    logic [2*BW-1:0] be_all;
    logic [2*DW-1:0] wd_all;

    assign off    = addr_q[OW-1:0];
    assign in_off = req_addr[OW-1:0];
    assign two    = (int'(off) + (1 << op_q[1:0])) > BW;
    assign in_mis = (int'(in_off) + (1 << req_op[1:0])) > BW;
    assign in_err = (req_op[1:0] == LSU_SZ_D && DW == 32) || (in_mis && ALLOW_MISALIGN == 0);
    assign base   = {addr_q[AW-1:OW], {OW{1'b0}}};
    // low half of each double-width vector feeds beat 0, high half feeds beat 1
    assign be_all = ((BE_ONE << (1 << op_q[1:0])) - BE_ONE) << off;
    assign wd_all = {{DW{1'b0}}, wdata_q} << {off, 3'b000};

    lsu_load_extend #(.DW(DW)) u_ext (
        .beats({beat1, beat0}),
        .off  (off),
        .op   (op_q),
        .data (load_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            op_q    <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            beat0   <= '0;
            beat1   <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && req_valid) begin
                addr_q  <= req_addr;
                op_q    <= req_op;
                we_q    <= req_we;
                wdata_q <= req_wdata;
                err_q   <= in_err;
                beat1   <= '0;
            end
            if (state == S_RD0 && mem_rvalid) beat0 <= mem_rdata;
            if (state == S_RD1 && mem_rvalid) beat1 <= mem_rdata;
        end
    end

    always_comb begin
        state_nx   = state;
        req_ready  = state == S_IDLE;
        mem_valid  = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = '0;
        mem_wdata  = '0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        case (state)
            S_IDLE: if (req_valid) state_nx = in_err ? S_RESP : S_CMD0;
            S_CMD0: begin
                mem_valid = 1'b1;
                mem_we    = we_q;
                mem_addr  = base;
                mem_be    = be_all[BW-1:0];
                mem_wdata = wd_all[DW-1:0];
                if (mem_ready) state_nx = !we_q ? S_RD0 : two ? S_CMD1 : S_RESP;
            end
            S_RD0: if (mem_rvalid) state_nx = two ? S_CMD1 : S_RESP;
            S_CMD1: begin
                mem_valid = 1'b1;
                mem_we    = we_q;
                mem_addr  = base + AW'(BW);
                mem_be    = be_all[2*BW-1:BW];
                mem_wdata = wd_all[2*DW-1:DW];
                if (mem_ready) state_nx = we_q ? S_RESP : S_RD1;
            end
            S_RD1: if (mem_rvalid) state_nx = S_RESP;
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (err_q || we_q) ? '0 : load_data;
                state_nx   = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_lsu_align_unit.sv
// tb_lsu_align_unit: random and directed loads/stores against a byte-array memory model,
// with responses checked by a scoreboard monitor.
module tb_lsu_align_unit;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [2:0]  req_op = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_valid, mem_ready = 1'b0, mem_we, mem_rvalid = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [3:0]  mem_be;

    logic        b_req_valid = 1'b0, b_req_ready, b_req_we = 1'b0;
    logic [2:0]  b_req_op = '0;
    logic [31:0] b_req_addr = '0, b_req_wdata = '0;
    logic        b_resp_valid, b_resp_err, b_mem_valid, b_mem_we;
    logic [31:0] b_resp_rdata, b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_be;

    always #5 clk = ~clk;

    lsu_align_unit #(.DW(32), .AW(32), .ALLOW_MISALIGN(1)) dut (
        .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    lsu_align_unit #(.DW(32), .AW(32), .ALLOW_MISALIGN(0)) dut_nm (
        .clk(clk), .reset(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_op(b_req_op), .req_addr(b_req_addr), .req_wdata(b_req_wdata), .resp_valid(b_resp_valid),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .mem_valid(b_mem_valid), .mem_ready(1'b1),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_be(b_mem_be), .mem_wdata(b_mem_wdata),
        .mem_rvalid(1'b1), .mem_rdata(32'hDEADBEEF)
    );

    typedef struct {logic [31:0] rdata; logic err; int lat; int t0;} exp_t;
    typedef struct {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;} cmd_t;

    exp_t        sb[$];
    cmd_t        log_q[$];
    logic [7:0]  bmem[1024];
    logic [7:0]  rmem[1024];
    int          errors = 0, checks = 0, cyc = 0, mode = 2, dly = 0;
    logic        pend = 1'b0;
    logic [31:0] pdata = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // reference: byte-addressed little-endian memory, one request completes before the next
    function automatic exp_t model(input logic we, input logic [2:0] op, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic lat_chk);
        exp_t e;
        int n, idx;
        logic mis;
        logic [63:0] v;
        n = 1 << op[1:0];
        v = '0;
        mis = (addr % 4) + n > 4;
        e.err = op[1:0] == 2'd3;
        e.rdata = '0;
        e.t0 = cyc;
        e.lat = (!lat_chk || e.err) ? 0 : we ? (mis ? 3 : 2) : (mis ? 5 : 3);
        if (!e.err) begin
            for (int i = 0; i < n; i++) begin
                idx = (int'(addr[9:0]) + i) % 1024;
                if (we) rmem[idx] = wdata[8*i +: 8];
                else v = v | (64'(rmem[idx]) << (8 * i));
            end
            if (!we) begin
                if (!op[2] && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
                e.rdata = v[31:0];
            end
        end
        return e;
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            bmem[(int'(a[9:0]) + i) % 1024] = w[8*i +: 8];
            rmem[(int'(a[9:0]) + i) % 1024] = w[8*i +: 8];
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic lat_chk);
        int k = 0;
        while (!req_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: req_ready=%b want 1", req_ready);
            return;
        end
        sb.push_back(model(we, op, addr, wdata, lat_chk));
        req_valid = 1'b1;
        req_we = we;
        req_op = op;
        req_addr = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((sb.size() != 0 || !req_ready) && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0 || !req_ready) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending=%0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic nm_probe(input logic we, input logic [2:0] op, input logic [31:0] addr,
                            output int mv, output int rv, output logic e, output logic [31:0] d);
        mv = 0;
        rv = 0;
        e = 1'b0;
        d = '0;
        b_req_valid = 1'b1;
        b_req_we = we;
        b_req_op = op;
        b_req_addr = addr;
        b_req_wdata = 32'h12345678;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            b_req_valid = 1'b0;
            mv += int'(b_mem_valid);
            if (b_resp_valid) begin
                rv++;
                e = b_resp_err;
                d = b_resp_rdata;
            end
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: resp_valid=1 want 0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", 32'(resp_err), 32'(e.err));
                if (e.lat != 0) check("latency", 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    end

    // bus responder: mode 0 zero-wait, mode 1 random stalls and stray rvalids, mode 2 manual
    initial begin
        forever begin
            @(negedge clk);
            if (mode != 2) begin
                if (pend && dly == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = pdata;
                    pend = 1'b0;
                end else begin
                    if (pend) dly--;
                    mem_rvalid = (!pend && mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
                    mem_rdata = $urandom;
                end
                mem_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
                if (mem_valid && mem_ready) begin
                    log_q.push_back('{mem_we, mem_addr, mem_be, mem_wdata});
                    if (mem_we) begin
                        for (int i = 0; i < 4; i++)
                            if (mem_be[i]) bmem[(int'(mem_addr[9:0]) + i) % 1024] = mem_wdata[8*i +: 8];
                    end else begin
                        pend = 1'b1;
                        dly = (mode == 1) ? $urandom_range(0, 2) : 0;
                        for (int i = 0; i < 4; i++) pdata[8*i +: 8] = bmem[(int'(mem_addr[9:0]) + i) % 1024];
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int mv, rv, seen;
        logic e;
        logic [31:0] d;
        for (int i = 0; i < 1024; i++) begin
            bmem[i] = 8'($urandom);
            rmem[i] = bmem[i];
        end
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_mem_valid", 32'(mem_valid), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_mem_be", 32'(mem_be), 0);
        rst_n = 1'b1;
        mode = 0;
        @(negedge clk);

        set_word(32'h1000, 32'h80FF7F01);
        issue(1'b0, 3'b000, 32'h1003, 0, 1'b1);
        issue(1'b0, 3'b100, 32'h1003, 0, 1'b1);
        drain();

        log_q.delete();
        issue(1'b1, 3'b001, 32'h2002, 32'h0000BEEF, 1'b1);
        drain();
        check("sh_beats", 32'(log_q.size()), 1);
        if (log_q.size() == 1) begin
            check("sh_addr", log_q[0].addr, 32'h2000);
            check("sh_be", 32'(log_q[0].be), 32'hC);
            check("sh_wdata", log_q[0].wdata, 32'hBEEF0000);
            check("sh_we", 32'(log_q[0].we), 1);
        end
        issue(1'b0, 3'b101, 32'h2002, 0, 1'b1);

        set_word(32'h3000, 32'h44332211);
        set_word(32'h3004, 32'h88776655);
        drain();
        log_q.delete();
        issue(1'b0, 3'b010, 32'h3003, 0, 1'b1);
        drain();
        check("lw_mis_beats", 32'(log_q.size()), 2);
        if (log_q.size() == 2) begin
            check("lw_mis_addr0", log_q[0].addr, 32'h3000);
            check("lw_mis_addr1", log_q[1].addr, 32'h3004);
        end

        log_q.delete();
        issue(1'b1, 3'b010, 32'h3002, 32'hAABBCCDD, 1'b1);
        drain();
        check("sw_mis_beats", 32'(log_q.size()), 2);
        if (log_q.size() == 2) begin
            check("sw_b0_addr", log_q[0].addr, 32'h3000);
            check("sw_b0_be", 32'(log_q[0].be), 32'hC);
            check("sw_b0_wdata", log_q[0].wdata, 32'hCCDD0000);
            check("sw_b1_addr", log_q[1].addr, 32'h3004);
            check("sw_b1_be", 32'(log_q[1].be), 32'h3);
            check("sw_b1_wdata", log_q[1].wdata, 32'h0000AABB);
        end
        issue(1'b0, 3'b010, 32'h3002, 0, 1'b1);

        drain();
        log_q.delete();
        issue(1'b0, 3'b011, 32'h0010, 0, 1'b0);
        issue(1'b1, 3'b111, 32'h0020, 32'h5555AAAA, 1'b0);
        drain();
        check("dword_no_bus", 32'(log_q.size()), 0);

        log_q.delete();
        issue(1'b1, 3'b010, 32'hFFFFFFFE, 32'h01020304, 1'b1);
        drain();
        check("wrap_beats", 32'(log_q.size()), 2);
        if (log_q.size() == 2) check("wrap_addr1", log_q[1].addr, 32'h0);
        issue(1'b0, 3'b010, 32'hFFFFFFFE, 0, 1'b1);
        drain();

        mode = 1;
        repeat (300) issue($urandom_range(0, 1) == 1, 3'($urandom), $urandom, $urandom, 1'b0);
        drain();
        mode = 0;
        repeat (100) issue($urandom_range(0, 1) == 1, 3'($urandom), $urandom, $urandom, 1'b1);
        drain();

        mode = 2;
        pend = 1'b0;
        mem_ready = 1'b0;
        mem_rvalid = 1'b0;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_op = 3'b010;
        req_addr = 32'h100;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("stall_mem_valid", 32'(mem_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_mem_valid", 32'(mem_valid), 0);
        check("async_req_ready", 32'(req_ready), 1);
        check("async_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 1);
        mem_rvalid = 1'b1;
        mem_rdata = $urandom;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            seen += int'(resp_valid);
        end
        mem_rvalid = 1'b0;
        check("late_rvalid_resp", 32'(seen), 0);
        mode = 0;
        issue(1'b0, 3'b001, 32'h0206, 0, 1'b1);
        drain();

        nm_probe(1'b0, 3'b001, 32'h0003, mv, rv, e, d);
        check("nm_lh_mem_valid", 32'(mv), 0);
        check("nm_lh_resp", 32'(rv), 1);
        check("nm_lh_err", 32'(e), 1);
        check("nm_lh_rdata", d, 0);
        nm_probe(1'b1, 3'b010, 32'h0002, mv, rv, e, d);
        check("nm_sw_mem_valid", 32'(mv), 0);
        check("nm_sw_err", 32'(e), 1);
        nm_probe(1'b0, 3'b010, 32'h0004, mv, rv, e, d);
        check("nm_lw_mem_valid", 32'(mv), 1);
        check("nm_lw_err", 32'(e), 0);
        check("nm_lw_rdata", d, 32'hDEADBEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
